// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared size encodings, FSM states and helpers for dmem_ctrl
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_RST,
    ST_INIT,
    ST_RUN
  } state_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane mask/shift for stores and lane extract/extend for loads
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [1:0]          size,
  input  logic                uns,
  input  logic [OFF_W-1:0]    offset,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W-1:0]   rword,
  output logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   wword,
  output logic [DATA_W-1:0]   rdata
);

  localparam int BYTES = DATA_W / 8;

  int                nbytes;
  logic [DATA_W-1:0] shifted;
  logic              msb;
  logic              fill;

  always_comb begin
    // Oversized requests are rejected upstream; clip so the lane math stays in range.
    nbytes = int'(size_bytes(size));
    if (nbytes > BYTES) nbytes = BYTES;

    be = '0;
    for (int i = 0; i < BYTES; i++)
      if (i < nbytes) be[i] = 1'b1;
    be    = be << offset;
    wword = wdata << {offset, 3'b000};

    shifted = rword >> {offset, 3'b000};
    case (size)
      SZ_B:    msb = shifted[7];
      SZ_H:    msb = shifted[15];
      SZ_W:    msb = shifted[31];
      default: msb = shifted[DATA_W-1];
    endcase
    fill = uns ? 1'b0 : msb;
    for (int i = 0; i < DATA_W; i++)
      rdata[i] = (i < nbytes * 8) ? shifted[i] : fill;
  end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - byte-addressable data memory with valid/ready requests and registered response
// Optional post-reset fill sweep enabled by defining DMEM_INIT_EN.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 256,
  parameter int ADDR_W   = 64,
  parameter int INIT_VAL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  state_t            state_nx;
  logic [OFF_W-1:0]  offset;
  logic [ADDR_W-1:0] idx_full;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        nbytes;
  logic              err;
  logic              accept;
  logic              wr_en;
  logic [BYTES-1:0]  be;
  logic [DATA_W-1:0] wword;
  logic [DATA_W-1:0] ld_data;

  always_comb begin
    offset   = req_addr[OFF_W-1:0];
    idx_full = req_addr >> OFF_W;
    idx      = idx_full[IDX_W-1:0];
    nbytes   = size_bytes(req_size);
    err      = (idx_full >= ADDR_W'(DEPTH))
            || ((4'(offset) & (nbytes - 4'd1)) != 4'd0)
            || (nbytes > 4'(BYTES));
    accept   = req_valid && req_ready;
    wr_en    = accept && req_we && !err;
  end

`ifdef DMEM_INIT_EN
  logic [IDX_W-1:0] init_idx;
  logic             init_we;

  // Counter only advances inside INIT, so any reset or exit restarts the sweep at word 0.
  always_ff @(posedge clk) begin
    if (rst || state != ST_INIT) init_idx <= '0;
    else                         init_idx <= init_idx + IDX_W'(1);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RST;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_RST: begin
`ifdef DMEM_INIT_EN
        state_nx = ST_INIT;
`else
        state_nx = ST_RUN;
`endif
      end
      ST_INIT: begin
`ifdef DMEM_INIT_EN
        if (init_idx == IDX_W'(DEPTH - 1)) state_nx = ST_RUN;
`else
        state_nx = ST_RUN;
`endif
      end
      ST_RUN:  state_nx = ST_RUN;
      default: state_nx = ST_RST;
    endcase
  end

  always_comb begin
    req_ready = (state == ST_RUN);
`ifdef DMEM_INIT_EN
    init_we   = (state == ST_INIT);
`endif
  end

  dmem_lane_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_lane_align (
    .size   (req_size),
    .uns    (req_unsigned),
    .offset (offset),
    .wdata  (req_wdata),
    .rword  (mem[idx]),
    .be     (be),
    .wword  (wword),
    .rdata  (ld_data)
  );

  // Contents are deliberately left out of reset; only the optional sweep fills them.
  always_ff @(posedge clk) begin
`ifdef DMEM_INIT_EN
    if (init_we) mem[init_idx] <= DATA_W'(INIT_VAL);
`endif
    if (wr_en)
      for (int b = 0; b < BYTES; b++)
        if (be[b]) mem[idx][b*8 +: 8] <= wword[b*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= accept;
      resp_err   <= accept && err;
      resp_rdata <= (accept && !err && !req_we) ? ld_data : '0;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed self-checking bench for dmem_ctrl (64-bit and 32-bit instances)
// Expectations adapt to DMEM_INIT_EN when it is defined.
module tb_dmem_ctrl;
  import dmem_pkg::*;

`ifdef DMEM_INIT_EN
  localparam int          READY_LAT = 257;
  localparam logic [63:0] POST_RST  = 64'h1;
`else
  localparam int          READY_LAT = 1;
  localparam logic [63:0] POST_RST  = 64'h7FFF456780ABCDEF;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata, resp_rdata;
  logic        resp_valid, resp_err;

  logic        v32, rdy32, we32, uns32, rv32, err32;
  logic [1:0]  sz32;
  logic [31:0] addr32, wd32, rd32;

  int checks   = 0;
  int failures = 0;

  dmem_ctrl u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_ctrl #(.DATA_W(32), .DEPTH(16), .ADDR_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .req_valid(v32), .req_ready(rdy32),
    .req_we(we32), .req_size(sz32), .req_unsigned(uns32),
    .req_addr(addr32), .req_wdata(wd32), .resp_valid(rv32),
    .resp_rdata(rd32), .resp_err(err32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!(req_ready && rdy32) && n < 2000) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(READY_LAT));
  endtask

  task automatic access(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wd,
                        input logic [63:0] exp_d, input logic exp_e);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    tick();
    req_valid = 1'b0;
    check({tag, "_valid"}, 64'(resp_valid), 64'd1);
    check({tag, "_data"}, resp_rdata, exp_d);
    check({tag, "_err"}, 64'(resp_err), 64'(exp_e));
    tick();
    check({tag, "_single"}, 64'(resp_valid), 64'd0);
  endtask

  task automatic access32(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_d, input logic exp_e);
    v32 = 1'b1; we32 = we; sz32 = sz; uns32 = uns; addr32 = addr; wd32 = wd;
    tick();
    v32 = 1'b0;
    check({tag, "_valid"}, 64'(rv32), 64'd1);
    check({tag, "_data"}, 64'(rd32), 64'(exp_d));
    check({tag, "_err"}, 64'(err32), 64'(exp_e));
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_D; req_unsigned = 1'b0;
    req_addr = 64'h0; req_wdata = 64'h0;
    v32 = 1'b0; we32 = 1'b0; sz32 = SZ_B; uns32 = 1'b0; addr32 = '0; wd32 = '0;

    repeat (3) begin
      tick();
      check("rst_ready", 64'(req_ready), 64'd0);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
    end
    check("rst_rdata", resp_rdata, 64'd0);
    check("rst_err", 64'(resp_err), 64'd0);

    rst = 1'b0;
    wait_ready("boot");
    check("idle_ignored", 64'(resp_valid), 64'd0);
    req_valid = 1'b0;
    check("n_ready", 64'(rdy32), 64'd1);

`ifdef DMEM_INIT_EN
    access("init_top", 1'b0, SZ_D, 1'b0, 64'h7F8, 64'h0, 64'h1, 1'b0);
`endif

    access("st_d",  1'b1, SZ_D, 1'b0, 64'h10, 64'h0123456789ABCDEF, 64'h0, 1'b0);
    access("ld_d",  1'b0, SZ_D, 1'b0, 64'h10, 64'h0, 64'h0123456789ABCDEF, 1'b0);
    access("st_b",  1'b1, SZ_B, 1'b0, 64'h13, 64'h1122334455667780, 64'h0, 1'b0);
    access("ld_bs", 1'b0, SZ_B, 1'b0, 64'h13, 64'h0, 64'hFFFFFFFFFFFFFF80, 1'b0);
    access("ld_bu", 1'b0, SZ_B, 1'b1, 64'h13, 64'h0, 64'h0000000000000080, 1'b0);
    access("ld_d2", 1'b0, SZ_D, 1'b0, 64'h10, 64'h0, 64'h0123456780ABCDEF, 1'b0);
    access("ld_hs", 1'b0, SZ_H, 1'b0, 64'h12, 64'h0, 64'hFFFFFFFFFFFF80AB, 1'b0);
    access("ld_wu", 1'b0, SZ_W, 1'b1, 64'h14, 64'h0, 64'h0000000001234567, 1'b0);
    access("ld_ws", 1'b0, SZ_W, 1'b0, 64'h10, 64'h0, 64'hFFFFFFFF80ABCDEF, 1'b0);
    access("st_h",  1'b1, SZ_H, 1'b0, 64'h16, 64'hAAAA7FFF, 64'h0, 1'b0);
    access("ld_hp", 1'b0, SZ_H, 1'b0, 64'h16, 64'h0, 64'h0000000000007FFF, 1'b0);
    access("ld_d3", 1'b0, SZ_D, 1'b0, 64'h10, 64'h0, 64'h7FFF456780ABCDEF, 1'b0);

    access("st_w0",   1'b1, SZ_D, 1'b0, 64'h0,  64'hAAAA5555AAAA5555, 64'h0, 1'b0);
    access("e_mis_h", 1'b0, SZ_H, 1'b0, 64'h11, 64'h0, 64'h0, 1'b1);
    access("e_oob_w", 1'b1, SZ_W, 1'b0, 64'h802, 64'hFFFFFFFF, 64'h0, 1'b1);
    access("e_oob_d", 1'b1, SZ_D, 1'b0, 64'h800, 64'h5, 64'h0, 1'b1);
    access("e_mis_d", 1'b1, SZ_D, 1'b0, 64'h14, 64'h5, 64'h0, 1'b1);
    access("e_hi",    1'b0, SZ_B, 1'b0, 64'h1_0000_0010, 64'h0, 64'h0, 1'b1);
    access("chk_w0",  1'b0, SZ_D, 1'b0, 64'h0,  64'h0, 64'hAAAA5555AAAA5555, 1'b0);
    access("chk_w2",  1'b0, SZ_D, 1'b0, 64'h10, 64'h0, 64'h7FFF456780ABCDEF, 1'b0);

    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_we = (i % 2 == 0); req_size = SZ_D; req_unsigned = 1'b0;
      req_addr  = 64'h20 + 64'(8 * (i / 2));
      req_wdata = 64'hC0DE000000000000 + 64'(i);
      tick();
      check("b2b_valid", 64'(resp_valid), 64'd1);
      check("b2b_data", resp_rdata, (i % 2 == 0) ? 64'h0 : 64'hC0DE000000000000 + 64'(i - 1));
    end
    req_valid = 1'b0;
    tick();
    check("b2b_end", 64'(resp_valid), 64'd0);

    access32("n_st_w",  1'b1, SZ_W, 1'b0, 32'h8, 32'h89ABCDEF, 32'h0, 1'b0);
    access32("n_d_st",  1'b1, SZ_D, 1'b0, 32'h8, 32'h0, 32'h0, 1'b1);
    access32("n_ld_w",  1'b0, SZ_W, 1'b0, 32'h8, 32'h0, 32'h89ABCDEF, 1'b0);
    access32("n_d_ld",  1'b0, SZ_D, 1'b0, 32'h8, 32'h0, 32'h0, 1'b1);
    access32("n_ld_hs", 1'b0, SZ_H, 1'b0, 32'hA, 32'h0, 32'hFFFF89AB, 1'b0);
    access32("n_ld_bu", 1'b0, SZ_B, 1'b1, 32'hB, 32'h0, 32'h00000089, 1'b0);
    tick();

    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_D; req_addr = 64'h10;
    tick();
    check("mid_accepted", 64'(resp_valid), 64'd1);
    rst = 1'b1; req_valid = 1'b0;
    tick();
    check("mid_dropped", 64'(resp_valid), 64'd0);
    check("mid_rdata", resp_rdata, 64'd0);
    tick();
    rst = 1'b0;
    wait_ready("rerun");
    access("post_rst", 1'b0, SZ_D, 1'b0, 64'h10, 64'h0, POST_RST, 1'b0);

`ifdef DMEM_INIT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (101) tick();
    check("sweep_busy", 64'(req_ready), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready("sweep_restart");
    access("sweep_fill", 1'b0, SZ_D, 1'b0, 64'h20, 64'h0, 64'h1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised, byte-addressable data memory for the datapath load/store stage.
- Supersedes the fixed 64-bit x 256 word array, which had only an asynchronous tri-state read.
- Adds a valid/ready request port, byte/half/word/double accesses with sign or zero extension, and a registered response with error flagging.
- Optional post-reset fill sweep.

Parameters:
- DATA_W, 64, word width in bits; legal values 32 or 64.
- DEPTH, 256, number of words.
- ADDR_W, 64, byte-address width.
- INIT_VAL, 1, fill value per word (used only with DMEM_INIT_EN).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  DATA_W  load result.
- resp_err  out  1  access rejected.

Behaviour:
- Handshake: a request is accepted at the edge where req_valid && req_ready. The response follows one cycle later: resp_valid = 1 for exactly one cycle.
- Throughput is one access per cycle, and no response backpressure exists. Stores also produce a response, with resp_rdata = 0.
- Address decode: BYTES = DATA_W/8; offset = req_addr[log2(BYTES)-1:0]; index = req_addr >> log2(BYTES).
- Error when any of the following holds:
  - index >= DEPTH;
  - offset is not a multiple of 2^req_size;
  - 2^req_size > BYTES (size 3 with DATA_W = 32).
- On error: the array is untouched, resp_err = 1, resp_rdata = 0.
- Store: writes only the 2^req_size byte lanes starting at offset, from the low bytes of req_wdata. Other lanes are preserved.
- Load: extracts the lanes at offset, then sign-extends (from the field MSB) or zero-extends to DATA_W. The array read is synchronous and is registered into resp_rdata.
- Ordering: a load accepted at cycle N+1 to an address stored at cycle N returns the new data. There is no bypass hazard because the write commits at edge N.
- FSM states: RST, INIT, RUN.
  - rst = 1 -> RST.
  - RST -> INIT (feature on) or RUN (feature off) on the first cycle with rst = 0.
  - INIT -> RUN after the sweep completes.
- req_ready = 1 only in RUN.
- Reset values: req_ready 0, resp_valid 0, resp_rdata 0, resp_err 0, state RST.
- Array contents are NOT cleared by reset unless DMEM_INIT_EN is set.
- Reset mid-operation: any in-flight response is dropped. resp_valid is 0 in the cycle after rst is sampled high.
- A request presented while req_ready = 0 is ignored and produces no response.

Optional Feature:
- DMEM_INIT_EN defined: INIT state writes INIT_VAL to word 0..DEPTH-1, one word per cycle, using an index counter.
  - INIT lasts exactly DEPTH cycles; req_ready rises on the cycle after the last word is written.
  - A reset during INIT restarts the sweep at word 0.
- DMEM_INIT_EN undefined: the INIT state and counter are absent. RUN is entered one cycle after rst deasserts, and contents are X until written.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_B, SZ_H, SZ_W, SZ_D;
  - the FSM state enum {ST_RST, ST_INIT, ST_RUN};
  - helper function size_bytes(size).
- Sub-module dmem_lane_align is combinational and covers:
  - store byte-mask and write-data shift generation;
  - load lane extraction and sign/zero extension.
- The top level holds the array, FSM, init counter and response registers.

Test Plan (DATA_W = 64, DEPTH = 256 unless stated):
- Reset sequencing:
  - Hold rst 3 cycles, then release -> req_ready = 0 during reset.
  - Without feature, req_ready = 1 one cycle after release.
  - With DMEM_INIT_EN: req_ready = 1 after 256 more cycles, and a double load at 0x7F8 returns 0x1.
- Double store then load: store 0x0123456789ABCDEF at 0x10, then load double at 0x10 the next cycle -> resp_rdata 0x0123456789ABCDEF, resp_err 0, one response per request.
- Byte sub-word access: store byte 0x80 at 0x13 over that word.
  - Signed byte load at 0x13 -> 0xFFFFFFFFFFFFFF80.
  - Unsigned -> 0x80.
  - Double load at 0x10 -> 0x0123456780ABCDEF.
- Error cases, each -> resp_err 1, resp_rdata 0, memory unchanged:
  - Misaligned half load at 0x11.
  - Word store at 0x802 (index 256).
  - With DATA_W = 32: size 3 request.
- Back-to-back stream: 8 consecutive accepted requests (alternating store/load, req_valid held high) -> 8 resp_valid pulses on consecutive cycles with correct data.
- Reset mid-operation: assert rst in the cycle after an accepted load -> no resp_valid. With DMEM_INIT_EN, reset at sweep word 100 -> sweep restarts and req_ready stays 0 for 256 cycles.
